// File: rtl/mul_unit.sv
// mul_unit: sequential signed n x n multiplier, one radix-2 shift-add step per cycle.
// The full product goes to prod. result is the Q1.(n-1) fractional product prod[2n-2:n-1],
// truncated toward minus infinity.
// Optional macro MUL_SAT_EN: when prod overflows the fractional range, result is clamped
// and sat is raised. Without the macro, result wraps and sat stays 0.
// Latency: start accepted at E0, busy after E0..En, done pulse after En, IDLE at E(n+1).
module mul_unit #(
  parameter int n = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  input  logic signed [n-1:0]   a,
  input  logic signed [n-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic signed [n-1:0]   result,
  output logic signed [2*n-1:0] prod,
  output logic                  sat
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic [2*n-1:0]   r_mcand;   // |a|, shifted left once per step
  logic [n-1:0]     r_mplier;  // |b|, shifted right once per step
  logic [2*n-1:0]   r_acc;

  logic [n-1:0]     w_mag_a, w_mag_b;
  logic [2*n-1:0]   w_step, w_prod;
  logic [n-1:0]     w_res_raw, w_res;
  logic             w_sat, w_last;

  // An n-bit magnitude path is enough: -2^(n-1) maps to 2^(n-1) as an unsigned value.
  assign w_mag_a   = a[n-1] ? (~a + 1'b1) : a;
  assign w_mag_b   = b[n-1] ? (~b + 1'b1) : b;
  assign w_step    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last    = (r_cnt == CW'(n - 1));
  assign w_prod    = r_neg ? (~w_step + 1'b1) : w_step;
  assign w_res_raw = w_prod[2*n-2:n-1];

  // Result clamp / wrap selection
  always_comb begin
    w_sat = 1'b0;
    w_res = w_res_raw;
`ifdef MUL_SAT_EN
    if (w_prod[2*n-1] != w_prod[2*n-2]) begin
      w_sat = 1'b1;
      w_res = {1'b0, {(n-1){1'b1}}};
    end
`endif
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register and registered busy/done decodes
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= (w_next == CALC);
      done    <= (w_next == DONE);
    end
  end

  // Operand capture and the shift-add datapath
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (r_state == IDLE && start) begin
      r_cnt    <= '0;
      r_neg    <= a[n-1] ^ b[n-1];
      r_mcand  <= {{n{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_acc    <= '0;
    end else if (r_state == CALC) begin
      r_cnt    <= r_cnt + CW'(1);
      r_acc    <= w_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  // Outputs load on the final step (entry to DONE) and hold until the next one
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      prod   <= '0;
      result <= '0;
      sat    <= 1'b0;
    end else if (r_state == CALC && w_last) begin
      prod   <= w_prod;
      result <= w_res;
      sat    <= w_sat;
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed vectors for mul_unit (n=8) with a queue scoreboard and a done monitor.
module tb_mul_unit;

  logic              clk = 1'b0;
  logic              n_reset;
  logic              start;
  logic signed [7:0] a, b;
  logic              busy, done, sat;
  logic signed [7:0] result;
  logic signed [15:0] prod;

  typedef struct packed {
    logic [15:0] p;
    logic [7:0]  r;
    logic        s;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_done = 0;

  mul_unit #(.n(8)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .prod(prod), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("prod",   {16'b0, prod},   {16'b0, e.p});
        check("result", {24'b0, result}, {24'b0, e.r});
        check("sat",    {31'b0, sat},    {31'b0, e.s});
      end
    end
  end

  // Wait until idle, present operands, let edge E0 accept them, drop start
  task automatic start_op(input logic [7:0] ia, input logic [7:0] ib);
    int k = 0;
    @(negedge clk);
    while ((busy || done) && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) check("idle_timeout", 32'd1, 32'd0);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Count busy cycles after E0 and confirm done follows
  task automatic measure_busy(input string name);
    int c = 0;
    @(negedge clk);
    while (busy === 1'b1 && c < 40) begin c++; @(negedge clk); end
    check(name, c, 32'd8);
    check({name, "_done"}, {31'b0, done}, 32'd1);
  endtask

  task automatic push(input logic [15:0] p, input logic [7:0] r, input logic s);
    exp_t e;
    e.p = p; e.r = r; e.s = s;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    n_reset = 1'b0; start = 1'b1; a = 8'h40; b = 8'h40;
    #3;
    check("rst_busy",   {31'b0, busy},   32'd0);
    check("rst_done",   {31'b0, done},   32'd0);
    check("rst_prod",   {16'b0, prod},   32'd0);
    check("rst_result", {24'b0, result}, 32'd0);
    check("rst_sat",    {31'b0, sat},    32'd0);
    // start held during reset must not be taken
    @(posedge clk); #1;
    check("no_accept_in_reset", {31'b0, busy}, 32'd0);
    @(negedge clk); n_reset = 1'b1;
    push(16'h1000, 8'h20, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    measure_busy("lat_40x40");

    push(16'h2000, 8'h40, 1'b0);
    start_op(8'h80, 8'hC0);
    measure_busy("lat_80xC0");

`ifdef MUL_SAT_EN
    push(16'h4000, 8'h7F, 1'b1);
`else
    push(16'h4000, 8'h80, 1'b0);
`endif
    start_op(8'h80, 8'h80);
    repeat (12) @(posedge clk);
    #1;
    check("hold_prod",   {16'b0, prod},   32'h4000);
    check("hold_busy",   {31'b0, busy},   32'd0);

    // continuous start: accepts at E0, E10, E20 only
    @(negedge clk);
    push(16'hFF81, 8'hFF, 1'b0);
    push(16'hFF81, 8'hFF, 1'b0);
    push(16'hFF81, 8'hFF, 1'b0);
    d0 = n_done;
    a = 8'h7F; b = 8'hFF; start = 1'b1;
    repeat (30) @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("cont_done_count", n_done - d0, 32'd3);
    check("cont_idle",       {31'b0, busy}, 32'd0);

    // reset at cycle 4 of CALC aborts with no done
    start_op(8'h40, 8'h40);
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b0;
    #1;
    check("abort_busy",   {31'b0, busy},   32'd0);
    check("abort_done",   {31'b0, done},   32'd0);
    check("abort_prod",   {16'b0, prod},   32'd0);
    check("abort_result", {24'b0, result}, 32'd0);
    check("abort_sat",    {31'b0, sat},    32'd0);
    @(negedge clk); @(negedge clk); n_reset = 1'b1;
    d0 = n_done;
    repeat (12) @(posedge clk);
    #1 check("abort_no_done", n_done - d0, 32'd0);
    push(16'hFF81, 8'hFF, 1'b0);
    start_op(8'h7F, 8'hFF);
    measure_busy("lat_after_abort");

    // start and operand changes during CALC are ignored
    push(16'h2000, 8'h40, 1'b0);
    start_op(8'h80, 8'hC0);
    @(posedge clk); #1 a = 8'h7F; b = 8'h7F; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; a = 8'h01;
    @(posedge clk); #1 start = 1'b0;
    d0 = n_done;
    repeat (12) @(posedge clk);
    #1;
    check("ignore_one_done", n_done - d0, 32'd1);

    check("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
